// File: rtl/pmem_loader_pkg.sv
// Shared constants for the program-memory loader: FSM encodings, default sync marker
// and the maximum word count helper.
package pmem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         ADDR_W_DEFAULT    = 4;
  localparam int         MAX_COUNT_DEFAULT = 1 << ADDR_W_DEFAULT;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_CSUM  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  function automatic int max_count(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/pmem_loader.sv
// Framed byte-stream writer for the microcontroller program memory; holds the core in reset
// until a frame loads cleanly. Define PMEM_LOADER_CSUM_EN to require a trailing XOR checksum.
module pmem_loader
  import pmem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 4,
  parameter int         INSTR_W   = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reload,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               pm_we,
  output logic [ADDR_W-1:0]  pm_waddr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               core_reset,
  output logic               done,
  output logic               err
);

  localparam int         MaxCount   = max_count(ADDR_W);
  // Bits of the hi byte that do not fit in the instruction word must be zero.
  localparam logic [15:0] HiMaskWide = 16'h00FF << (INSTR_W - 8);
  localparam logic [7:0]  HiMask     = HiMaskWide[7:0];

  logic [2:0]      state;
  logic            armed;
  logic [ADDR_W:0] n_q;
  logic [ADDR_W:0] wcnt;
  logic [7:0]      hi_q;
  logic            accept;
  logic            count_ok;
  logic            hi_ok;
  logic            last_word;
`ifdef PMEM_LOADER_CSUM_EN
  logic [7:0]      csum_q;
`endif

  assign accept     = in_valid && in_ready;
  assign count_ok   = (in_data != 8'd0) && (int'(in_data) <= MaxCount);
  assign hi_ok      = (in_data & HiMask) == 8'd0;
  assign last_word  = (wcnt + 1'b1) == n_q;

  assign in_ready   = armed && (state != ST_DONE);
  assign done       = (state == ST_DONE);
  assign err        = (state == ST_ERR);
  assign core_reset = (state != ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      armed    <= 1'b0;
      n_q      <= '0;
      wcnt     <= '0;
      hi_q     <= '0;
      pm_we    <= 1'b0;
      pm_waddr <= '0;
      pm_wdata <= '0;
`ifdef PMEM_LOADER_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      armed <= 1'b1;
      pm_we <= 1'b0;
      // reload wins over a byte arriving in the same cycle; that byte is dropped.
      if (reload && (state == ST_DONE || state == ST_ERR)) begin
        state <= ST_IDLE;
      end else if (accept) begin
        case (state)
          ST_IDLE: begin
            if (in_data == SYNC_BYTE) state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (count_ok) begin
              n_q   <= (ADDR_W+1)'(in_data);
              wcnt  <= '0;
              state <= ST_HI;
`ifdef PMEM_LOADER_CSUM_EN
              csum_q <= in_data;
`endif
            end else begin
              state <= ST_ERR;
            end
          end
          ST_HI: begin
            if (hi_ok) begin
              hi_q  <= in_data;
              state <= ST_LO;
`ifdef PMEM_LOADER_CSUM_EN
              csum_q <= csum_q ^ in_data;
`endif
            end else begin
              state <= ST_ERR;
            end
          end
          ST_LO: begin
            pm_we    <= 1'b1;
            pm_waddr <= wcnt[ADDR_W-1:0];
            pm_wdata <= INSTR_W'({hi_q, in_data});
            wcnt     <= wcnt + 1'b1;
`ifdef PMEM_LOADER_CSUM_EN
            csum_q   <= csum_q ^ in_data;
            state    <= last_word ? ST_CSUM : ST_HI;
`else
            state    <= last_word ? ST_DONE : ST_HI;
`endif
          end
`ifdef PMEM_LOADER_CSUM_EN
          ST_CSUM: begin
            state <= (in_data == csum_q) ? ST_DONE : ST_ERR;
          end
`endif
          ST_ERR: begin
            if (in_data == SYNC_BYTE) state <= ST_COUNT;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed self-checking bench for pmem_loader; follows PMEM_LOADER_CSUM_EN the same way
// the design does, appending checksum bytes only when the macro is defined.
module tb_pmem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        reload;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        pm_we;
  logic [3:0]  pm_waddr;
  logic [11:0] pm_wdata;
  logic        core_reset;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [3:0]  wr_addr [256];
  logic [11:0] wr_data [256];
  int          wr_cnt = 0;

  pmem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .pm_we      (pm_we),
    .pm_waddr   (pm_waddr),
    .pm_wdata   (pm_wdata),
    .core_reset (core_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Logs every write pulse mid-cycle so each one-cycle pm_we is seen exactly once.
  always @(negedge clk) begin
    if (pm_we) begin
      if (wr_cnt < 256) begin
        wr_addr[wr_cnt] <= pm_waddr;
        wr_data[wr_cnt] <= pm_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout byte=%h in_ready=%b required=1", b, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic send_basic_frame();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h04);
    send_byte(8'h56);
`ifdef PMEM_LOADER_CSUM_EN
    send_byte(8'h02 ^ 8'h01 ^ 8'h23 ^ 8'h04 ^ 8'h56);
`endif
    idle_bus();
  endtask

  task automatic test_reset();
    reset = 1'b1; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, pm_we, pm_waddr, pm_wdata, core_reset, done, err} !== {1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h cr=%b dn=%b er=%b required 0 0 0 000 1 0 0",
               in_ready, pm_we, pm_waddr, pm_wdata, core_reset, done, err);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic_frame(input logic garbage);
    int base;
    base = wr_cnt;
    if (garbage) begin
      send_byte(8'h00);
      send_byte(8'hFF);
    end
    send_basic_frame();
    checks++;
    if ({done, core_reset, err} !== 3'b100) begin
      errors++;
      $display("FAIL frame_done g=%0b got done=%b cr=%b err=%b required 1 0 0", garbage, done, core_reset, err);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_done got %b required 0", in_ready);
    end
    wait_cycles(3);
    checks++;
    if (wr_cnt - base != 2) begin
      errors++;
      $display("FAIL frame_write_count got %0d required 2", wr_cnt - base);
    end else begin
      checks++;
      if ({wr_addr[base], wr_data[base]} !== {4'h0, 12'h123}) begin
        errors++;
        $display("FAIL frame_word0 got a=%h d=%h required a=0 d=123", wr_addr[base], wr_data[base]);
      end
      checks++;
      if ({wr_addr[base+1], wr_data[base+1]} !== {4'h1, 12'h456}) begin
        errors++;
        $display("FAIL frame_word1 got a=%h d=%h required a=1 d=456", wr_addr[base+1], wr_data[base+1]);
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_sticky got %b required 1", done);
    end
    pulse_reload();
    checks++;
    if ({done, core_reset, in_ready} !== 3'b011) begin
      errors++;
      $display("FAIL reload_from_done got done=%b cr=%b rdy=%b required 0 1 1", done, core_reset, in_ready);
    end
  endtask

  task automatic test_zero_count();
    int base;
    base = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    idle_bus();
    checks++;
    if ({err, core_reset, done} !== 3'b110) begin
      errors++;
      $display("FAIL zero_count_err got err=%b cr=%b done=%b required 1 1 0", err, core_reset, done);
    end
    wait_cycles(2);
    checks++;
    if (wr_cnt != base) begin
      errors++;
      $display("FAIL zero_count_nowrite got %0d writes required 0", wr_cnt - base);
    end
    send_byte(8'hA5);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_by_sync got %b required 0", err);
    end
    send_byte(8'h01);
    send_byte(8'h0F);
    send_byte(8'hFF);
`ifdef PMEM_LOADER_CSUM_EN
    send_byte(8'hF1);
`endif
    idle_bus();
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++;
      $display("FAIL recover_done got done=%b err=%b required 1 0", done, err);
    end
    wait_cycles(2);
    checks++;
    if (wr_cnt - base != 1 || {wr_addr[base], wr_data[base]} !== {4'h0, 12'hFFF}) begin
      errors++;
      $display("FAIL recover_write got n=%0d a=%h d=%h required n=1 a=0 d=fff", wr_cnt - base, wr_addr[base], wr_data[base]);
    end
    pulse_reload();
  endtask

  task automatic test_count_limit();
    int base;
    logic [7:0] csum;
    logic [7:0] hi;
    logic [7:0] lo;
    send_byte(8'hA5);
    send_byte(8'h11);
    idle_bus();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL count17_err got %b required 1", err);
    end
    pulse_reload();
    checks++;
    if ({err, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reload_from_err got err=%b rdy=%b required 0 1", err, in_ready);
    end
    base = wr_cnt;
    csum = 8'h10;
    send_byte(8'hA5);
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      hi = 8'(i);
      lo = 8'(i * 7 + 1);
      csum = csum ^ hi ^ lo;
      send_byte(hi);
      send_byte(lo);
    end
`ifdef PMEM_LOADER_CSUM_EN
    send_byte(csum);
`endif
    idle_bus();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL count16_done got %b required 1", done);
    end
    wait_cycles(2);
    checks++;
    if (wr_cnt - base != 16) begin
      errors++;
      $display("FAIL count16_writes got %0d required 16", wr_cnt - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if ({wr_addr[base+i], wr_data[base+i]} !== {4'(i), 4'(i), 8'(i * 7 + 1)}) begin
          errors++;
          $display("FAIL count16_word%0d got a=%h d=%h required a=%h d=%h", i,
                   wr_addr[base+i], wr_data[base+i], 4'(i), {4'(i), 8'(i * 7 + 1)});
        end
      end
    end
    pulse_reload();
  endtask

  task automatic test_bad_hi();
    int base;
    base = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    idle_bus();
    checks++;
    if ({err, core_reset} !== 2'b11) begin
      errors++;
      $display("FAIL bad_hi_err got err=%b cr=%b required 1 1", err, core_reset);
    end
    send_byte(8'h00);
    idle_bus();
    wait_cycles(2);
    checks++;
    if (wr_cnt != base || err !== 1'b1) begin
      errors++;
      $display("FAIL bad_hi_nowrite got writes=%0d err=%b required 0 1", wr_cnt - base, err);
    end
    pulse_reload();
  endtask

`ifdef PMEM_LOADER_CSUM_EN
  task automatic test_bad_csum();
    int base;
    base = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h00);
    idle_bus();
    checks++;
    if ({err, core_reset, done} !== 3'b110) begin
      errors++;
      $display("FAIL bad_csum_err got err=%b cr=%b done=%b required 1 1 0", err, core_reset, done);
    end
    wait_cycles(2);
    checks++;
    if (wr_cnt - base != 1 || {wr_addr[base], wr_data[base]} !== {4'h0, 12'h123}) begin
      errors++;
      $display("FAIL bad_csum_write got n=%0d a=%h d=%h required n=1 a=0 d=123", wr_cnt - base, wr_addr[base], wr_data[base]);
    end
    pulse_reload();
  endtask
`endif

  task automatic test_reload_priority();
    int base;
    send_byte(8'hA5);
    send_byte(8'h00);
    idle_bus();
    base = wr_cnt;
    // Sync byte coincident with reload must be dropped, leaving the loader in IDLE.
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk); #1;
    reload = 1'b0;
    idle_bus();
    send_byte(8'h01);
    send_byte(8'h0F);
    send_byte(8'hFF);
    send_byte(8'hF1);
    idle_bus();
    wait_cycles(2);
    checks++;
    if ({done, err} !== 2'b00 || wr_cnt != base) begin
      errors++;
      $display("FAIL reload_priority got done=%b err=%b writes=%0d required 0 0 0", done, err, wr_cnt - base);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h01);
    idle_bus();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, pm_we, pm_waddr, pm_wdata, core_reset, done, err} !== {1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset got rdy=%b we=%b a=%h d=%h cr=%b dn=%b er=%b required 0 0 0 000 1 0 0",
               in_ready, pm_we, pm_waddr, pm_wdata, core_reset, done, err);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    base = wr_cnt;
    send_basic_frame();
    wait_cycles(2);
    checks++;
    if (done !== 1'b1 || wr_cnt - base != 2) begin
      errors++;
      $display("FAIL post_reset_frame got done=%b writes=%0d required 1 2", done, wr_cnt - base);
    end else begin
      checks++;
      if ({wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]} !== {4'h0, 12'h123, 4'h1, 12'h456}) begin
        errors++;
        $display("FAIL post_reset_words got %h:%h %h:%h required 0:123 1:456",
                 wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame(1'b0);
    test_basic_frame(1'b1);
    test_zero_count();
    test_count_limit();
    test_bad_hi();
`ifdef PMEM_LOADER_CSUM_EN
    test_bad_csum();
`endif
    test_reload_priority();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
